// File: rtl/ride_queue_pkg.sv
// Shared constants for the ride queue controller: command bit positions,
// count width, arm-state encoding and active-low seven-segment patterns.
package ride_queue_pkg;

    localparam int CNT_W = 8;

    localparam int CMD_ADD1 = 0;
    localparam int CMD_ADD2 = 1;
    localparam int CMD_ADD3 = 2;
    localparam int CMD_RIDE = 3;

    typedef enum logic {
        ST_ARMED  = 1'b0,
        ST_LOCKED = 1'b1
    } arm_state_t;

    // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };
    localparam logic [6:0] SEG_ZERO = SEG_DIGITS[0];

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit, input logic blank);
        if (blank || (digit > 4'd9)) begin
            return SEG_BLANK;
        end
        return SEG_DIGITS[digit];
    endfunction

endpackage

// File: rtl/ride_queue_seg7_dec.sv
// Single-digit seven-segment decoder; digits above 9 or a blank request
// produce an all-dark pattern.
module seg7_dec
    import ride_queue_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = seg_pattern(digit, blank);

endmodule

// File: rtl/ride_queue_ctrl.sv
// Ride queue counter: tick-qualified one-hot commands add people or dispatch
// rides. Optional HEX display outputs are built when RIDE_QUEUE_SEG_EN is defined.
module ride_queue_ctrl
    import ride_queue_pkg::*;
#(
    parameter int STEP     = 4,
    parameter int RIDE_CAP = 8,
    parameter int MAX_WAIT = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       tick,
    input  logic [3:0] cmd,
    output logic [6:0] wait_cnt,
    output logic [3:0] rides_avail,
    output logic [7:0] rides_done,
    output logic       err
`ifdef RIDE_QUEUE_SEG_EN
    ,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX3
`endif
);

    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] CAP_W  = CNT_W'(RIDE_CAP);
    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_WAIT);

    arm_state_t       state_reg, state_next;
    logic [CNT_W-1:0] wait_reg, wait_next;
    logic [3:0]       avail_reg, avail_next;
    logic [7:0]       done_reg, done_next;
    logic             err_reg, err_next;

    logic             cmd_valid;
    logic [CNT_W-1:0] add_amt;
    logic [CNT_W-1:0] add_sum;

    assign cmd_valid = $onehot(cmd);

    always_comb begin
        add_amt = '0;
        if (cmd[CMD_ADD1]) begin
            add_amt = STEP_W;
        end else if (cmd[CMD_ADD2]) begin
            add_amt = CNT_W'(2 * STEP);
        end else if (cmd[CMD_ADD3]) begin
            add_amt = CNT_W'(3 * STEP);
        end
    end

    assign add_sum = wait_reg + add_amt;

    // A held switch is accepted once; only a tick with no command re-arms.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        if (tick) begin
            if (!cmd_valid) begin
                state_next = ST_ARMED;
            end else if (state_reg == ST_ARMED) begin
                state_next = ST_LOCKED;
                if (cmd[CMD_RIDE]) begin
                    if (wait_reg >= CAP_W) begin
                        wait_next = wait_reg - CAP_W;
                        done_next = done_reg + 8'd1;
                        err_next  = 1'b0;
                    end else begin
                        err_next  = 1'b1;
                    end
                end else if (add_sum <= MAX_W) begin
                    wait_next = add_sum;
                    err_next  = 1'b0;
                end else begin
                    err_next  = 1'b1;
                end
            end
        end
        avail_next = 4'(wait_next / CAP_W);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= ST_ARMED;
            wait_reg  <= '0;
            avail_reg <= '0;
            done_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            avail_reg <= avail_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign wait_cnt    = wait_reg[6:0];
    assign rides_avail = avail_reg;
    assign rides_done  = done_reg;
    assign err         = err_reg;

`ifdef RIDE_QUEUE_SEG_EN
    // Digits are decoded from the next-state values so the displays are
    // registered alongside wait_cnt and rides_avail.
    logic [3:0] dig_next [3];
    logic       blk_next [3];
    logic [6:0] seg_next [3];
    logic [6:0] hex_reg  [3];

    assign dig_next[0] = 4'(wait_next % 8'd10);
    assign blk_next[0] = 1'b0;
    assign dig_next[1] = 4'(wait_next / 8'd10);
    assign blk_next[1] = (wait_next < 8'd10);
    assign dig_next[2] = avail_next;
    assign blk_next[2] = 1'b0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_seg
        seg7_dec u_dec (
            .digit (dig_next[gi]),
            .blank (blk_next[gi]),
            .seg   (seg_next[gi])
        );

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                hex_reg[gi] <= (gi == 1) ? SEG_BLANK : SEG_ZERO;
            end else begin
                hex_reg[gi] <= seg_next[gi];
            end
        end
    end

    assign HEX0 = hex_reg[0];
    assign HEX1 = hex_reg[1];
    assign HEX3 = hex_reg[2];
`endif

endmodule

// File: tb/tb_ride_queue_ctrl.sv
// Bench for ride_queue_ctrl: directed scenarios plus random ticks/commands,
// checked every cycle against an arithmetic model of the queue rules.
module tb_ride_queue_ctrl;

    localparam int STEP     = 4;
    localparam int RIDE_CAP = 8;
    localparam int MAX_WAIT = 20;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       tick     = 1'b0;
    logic [3:0] cmd      = 4'b0000;
    logic [6:0] wait_cnt;
    logic [3:0] rides_avail;
    logic [7:0] rides_done;
    logic       err;
`ifdef RIDE_QUEUE_SEG_EN
    logic [6:0] HEX0, HEX1, HEX3;
`endif

    ride_queue_ctrl #(.STEP(STEP), .RIDE_CAP(RIDE_CAP), .MAX_WAIT(MAX_WAIT)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .tick        (tick),
        .cmd         (cmd),
        .wait_cnt    (wait_cnt),
        .rides_avail (rides_avail),
        .rides_done  (rides_done),
        .err         (err)
`ifdef RIDE_QUEUE_SEG_EN
        ,
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX3        (HEX3)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers updated by the queue rules.
    int m_wait  = 0;
    int m_done  = 0;
    bit m_err   = 0;
    bit m_armed = 1;

    function automatic int add_of(input logic [3:0] c);
        if (c[0]) return STEP;
        if (c[1]) return 2 * STEP;
        return 3 * STEP;
    endfunction

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            m_wait  <= 0;
            m_done  <= 0;
            m_err   <= 0;
            m_armed <= 1;
        end else if (tick) begin
            if ($countones(cmd) != 1) begin
                m_armed <= 1;
            end else if (m_armed) begin
                m_armed <= 0;
                if (cmd[3]) begin
                    if (m_wait >= RIDE_CAP) begin
                        m_wait <= m_wait - RIDE_CAP;
                        m_done <= (m_done + 1) % 256;
                        m_err  <= 0;
                    end else begin
                        m_err  <= 1;
                    end
                end else if (m_wait + add_of(cmd) <= MAX_WAIT) begin
                    m_wait <= m_wait + add_of(cmd);
                    m_err  <= 0;
                end else begin
                    m_err  <= 1;
                end
            end
        end
    end

`ifdef RIDE_QUEUE_SEG_EN
    function automatic int seg_of(input int d, input bit blank);
        if (blank || d > 9) return 7'h7F;
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction
`endif

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("wait_cnt", int'(wait_cnt), m_wait);
            check("rides_avail", int'(rides_avail), m_wait / RIDE_CAP);
            check("rides_done", int'(rides_done), m_done);
            check("err", int'(err), int'(m_err));
`ifdef RIDE_QUEUE_SEG_EN
            check("HEX0", int'(HEX0), seg_of(m_wait % 10, 1'b0));
            check("HEX1", int'(HEX1), seg_of(m_wait / 10, (m_wait / 10) == 0));
            check("HEX3", int'(HEX3), seg_of(m_wait / RIDE_CAP, 1'b0));
`endif
        end
    end

    task automatic cyc(input logic t, input logic [3:0] c);
        tick = t;
        cmd  = c;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick    = 1'b0;
        cmd     = 4'b0000;
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        logic [3:0] rc;
        logic [3:0] prev_c;
        prev_c = 4'b0000;

        do_reset();
        cmp_en = 1'b1;
        check("reset wait_cnt", int'(wait_cnt), 0);
        check("reset rides_done", int'(rides_done), 0);
        check("reset err", int'(err), 0);

        // Held +STEP over three ticks is accepted once.
        repeat (3) cyc(1'b1, 4'b0001);
        $display("held add x3: wait_cnt=%0d err=%0d", wait_cnt, err);
        check("held add wait_cnt", int'(wait_cnt), 4);
        check("held add err", int'(err), 0);

        // From 0: +8, release, +12.
        do_reset();
        cyc(1'b1, 4'b0010);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0100);
        $display("fill to max: wait_cnt=%0d rides_avail=%0d", wait_cnt, rides_avail);
        check("fill wait_cnt", int'(wait_cnt), 20);
        check("fill rides_avail", int'(rides_avail), 2);
`ifdef RIDE_QUEUE_SEG_EN
        check("fill HEX0", int'(HEX0), 7'h40);
        check("fill HEX1", int'(HEX1), 7'h24);
`endif

        // Overflow rejected, then dispatch accepted.
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0001);
        $display("overflow add: wait_cnt=%0d err=%0d", wait_cnt, err);
        check("overflow wait_cnt", int'(wait_cnt), 20);
        check("overflow err", int'(err), 1);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b1000);
        $display("dispatch: wait_cnt=%0d err=%0d rides_done=%0d", wait_cnt, err, rides_done);
        check("dispatch wait_cnt", int'(wait_cnt), 12);
        check("dispatch err", int'(err), 0);
        check("dispatch rides_done", int'(rides_done), 1);

        // Underflow dispatch at 4, then multi-hot is ignored.
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b1000);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b1000);
        $display("short dispatch: wait_cnt=%0d err=%0d rides_done=%0d", wait_cnt, err, rides_done);
        check("short wait_cnt", int'(wait_cnt), 4);
        check("short err", int'(err), 1);
        check("short rides_done", int'(rides_done), 2);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0011);
        check("multihot wait_cnt", int'(wait_cnt), 4);
        cyc(1'b1, 4'b0001);
        check("armed after multihot", int'(wait_cnt), 8);

        // Reset while a switch is held: accepted again after release.
        cyc(1'b1, 4'b0001);
        RESET_N = 1'b0;
        cyc(1'b0, 4'b0001);
        RESET_N = 1'b1;
        cyc(1'b1, 4'b0001);
        $display("held through reset: wait_cnt=%0d", wait_cnt);
        check("held through reset", int'(wait_cnt), 4);

        // rides_done wraps after 256 accepted dispatches.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            cyc(1'b1, 4'b0010);
            cyc(1'b1, 4'b0000);
            cyc(1'b1, 4'b1000);
            cyc(1'b1, 4'b0000);
        end
        check("rides_done 255", int'(rides_done), 255);
        cyc(1'b1, 4'b0010);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b1000);
        $display("wrap: rides_done=%0d", rides_done);
        check("rides_done wrap", int'(rides_done), 0);

        // Asynchronous reset between edges at wait_cnt=16.
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0010);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0010);
        check("pre-reset wait_cnt", int'(wait_cnt), 16);
        @(negedge CLOCK_50);
        #2;
        RESET_N = 1'b0;
        #1;
        $display("async reset: wait_cnt=%0d rides_avail=%0d err=%0d", wait_cnt, rides_avail, err);
        check("async wait_cnt", int'(wait_cnt), 0);
        check("async rides_avail", int'(rides_avail), 0);
        check("async rides_done", int'(rides_done), 0);
        check("async err", int'(err), 0);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;

        // Random ticks and commands, checked every cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    rc = 4'b0000;
                2, 3:    rc = 4'b0001;
                4:       rc = 4'b0010;
                5:       rc = 4'b0100;
                6, 7:    rc = 4'b1000;
                8:       rc = 4'($urandom_range(0, 15));
                default: rc = prev_c;
            endcase
            prev_c = rc;
            cyc(1'($urandom_range(0, 2) != 0), rc);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ride_queue_ctrl.md
RIDE_QUEUE_CTRL -- requirements
Module: ride_queue_ctrl

Interface
REQ-001 Parameter STEP, default 4, people added per small-group command.
REQ-002 Parameter RIDE_CAP, default 8, people removed per ride dispatch.
REQ-003 Parameter MAX_WAIT, default 20, queue capacity; legal range RIDE_CAP..99.
REQ-004 CLOCK_50  in  1  system clock; one clock; all state on rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-cycle sample strobe from the slow-clock divider.
REQ-007 cmd  in  4  one-hot command: [0] +STEP, [1] +2*STEP, [2] +3*STEP, [3] dispatch ride.
REQ-008 wait_cnt  out  7  registered people-waiting count.
REQ-009 rides_avail  out  4  registered floor(wait_cnt / RIDE_CAP).
REQ-010 rides_done  out  8  registered count of accepted dispatches, wraps 255->0.
REQ-011 err  out  1  sticky: last valid command was rejected.
REQ-012 HEX0, HEX1, HEX3  out  7 each  active-low segment digits; present only with RIDE_QUEUE_SEG_EN.

Function
REQ-013 cmd is valid only when exactly one bit is set; 4'b0000 and multi-hot are "no command".
REQ-014 Armed flag: a valid cmd is accepted only on a cycle with tick=1 and armed=1; acceptance clears armed.
REQ-015 armed re-sets on a tick=1 cycle where cmd is no command; holding a switch yields exactly one acceptance.
REQ-016 Cycles with tick=0 change no state.
REQ-017 Add command: if wait_cnt + k*STEP <= MAX_WAIT, wait_cnt increments by k*STEP on the accepting edge and err clears; else wait_cnt holds and err sets.
REQ-018 Dispatch: if wait_cnt >= RIDE_CAP, wait_cnt decrements by RIDE_CAP, rides_done increments, err clears; else all hold and err sets.
REQ-019 A rejected command still clears armed.
REQ-020 rides_avail and digit outputs reflect the new wait_cnt in the same cycle wait_cnt updates (all registered, latency 1 edge from accepting tick).
REQ-021 Arithmetic at 8-bit internal width; no wrap of wait_cnt ever occurs.

Reset
REQ-022 RESET_N low: wait_cnt=0, rides_avail=0, rides_done=0, err=0, armed=1, immediately and independent of CLOCK_50.
REQ-023 Reset asserted mid-press: after release, a still-held switch is accepted on the next tick (armed=1).

Configuration
REQ-024 With RIDE_QUEUE_SEG_EN defined: HEX0 = wait_cnt ones digit, HEX1 = tens digit (blank when tens=0), HEX3 = rides_avail digit (blank above 9), all registered, reset to "0","blank","0".
REQ-025 Without RIDE_QUEUE_SEG_EN: HEX ports and decode logic absent; binary outputs unchanged.

Structure
REQ-026 Package ride_queue_pkg holds command bit indices, seven-segment patterns 0-9 and blank, and the count width constant.
REQ-027 One sub-module seg7_dec (4-bit digit + blank in, 7-bit active-low pattern out), instantiated three times under RIDE_QUEUE_SEG_EN.

Verification
REQ-028 Reset, then cmd=0001 held over 3 ticks -> wait_cnt=4 only, err=0.
REQ-029 From 0: +8, release, +12 -> wait_cnt=20, rides_avail=2, HEX1/HEX0="2","0".
REQ-030 At 20, cmd=0001 on tick -> wait_cnt stays 20, err=1; next accepted dispatch -> wait_cnt=12, err=0, rides_done=1.
REQ-031 At 4, dispatch -> wait_cnt=4, err=1, rides_done unchanged; cmd=0011 on tick -> no change, armed unaffected.
REQ-032 255 dispatches (refilling between) then one more -> rides_done wraps to 0.
REQ-033 RESET_N pulsed low between clock edges with wait_cnt=16 -> all outputs zero before next edge.
